// File: rtl/clk_div_pkg.sv
// Shared types for the programmable clock divider.
// State encoding is exported on state_o for debug.
package clk_div_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and registered clk_out/tick generator.
// load parks the output low; run advances the counter.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int HALF_W = 8
) (
    input  logic              clk,
    input  logic              w_rst,
    input  logic              load,
    input  logic              run,
    input  logic [HALF_W-1:0] half,
    output logic              clk_out,
    output logic              tick,
    output logic              boundary
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              clk_q, clk_d;
    logic              tick_q, tick_d;
    logic              wrap;

    assign wrap     = (cnt_q == half - HALF_W'(1));
    assign boundary = run & clk_q & wrap;
    assign clk_out  = clk_q;
    assign tick     = tick_q;

    // Count within a phase; toggle the output and flag rising edges on wrap.
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (load) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (run) begin
            if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + HALF_W'(1);
            end
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider controller.
// Ratio changes land only at the end of a high phase.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int HALF_W   = 8,
    parameter int DEF_HALF = 1
) (
    input  logic              clk,
    input  logic              w_rst,
    input  logic              en,
    input  logic              cfg_valid,
    input  logic [HALF_W-1:0] cfg_half,
    output logic              cfg_ready,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
    output logic [ST_W-1:0]   state_o
);

    state_t            state_q, state_d;
    logic [HALF_W-1:0] cur_half_q, cur_half_d;
    logic [HALF_W-1:0] pend_half_q, pend_half_d;
    logic              pend_vld_q, pend_vld_d;
    logic              accept;
    logic              pend_any;
    logic [HALF_W-1:0] new_half;
    logic [HALF_W-1:0] half_nx;
    logic              boundary;
    logic              load;

    assign accept    = cfg_valid & ~pend_vld_q;
    assign pend_any  = pend_vld_q | accept;
    assign new_half  = pend_vld_q ? pend_half_q : cfg_half;
    assign half_nx   = pend_any ? new_half : cur_half_q;
    assign cfg_ready = ~pend_vld_q;
    assign load      = (state_q == STOP);
    assign busy      = (state_q != STOP);
    assign state_o   = state_q;

    clk_div_core #(
        .HALF_W (HALF_W)
    ) u_core (
        .clk      (clk),
        .w_rst    (w_rst),
        .load     (load),
        .run      (~load),
        .half     (cur_half_q),
        .clk_out  (clk_out),
        .tick     (tick),
        .boundary (boundary)
    );

    // Next state, handshake capture and boundary-aligned ratio apply.
    always_comb begin
        state_d     = state_q;
        cur_half_d  = cur_half_q;
        pend_half_d = pend_half_q;
        pend_vld_d  = pend_vld_q;
        if (accept) begin
            pend_half_d = cfg_half;
            pend_vld_d  = 1'b1;
        end
        unique case (state_q)
            STOP: begin
                if (accept) begin
                    cur_half_d = cfg_half;
                    pend_vld_d = 1'b0;
                end
                if (en && (half_nx != '0)) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (boundary) begin
                    if (pend_any) begin
                        cur_half_d = new_half;
                        pend_vld_d = 1'b0;
                    end
                    if (!en || (half_nx == '0)) begin
                        state_d = STOP;
                    end else begin
                        state_d = RUN;
                    end
                end else if (pend_any) begin
                    if ((state_q == DRAIN) && !en) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = PEND;
                    end
                end else begin
                    state_d = en ? RUN : DRAIN;
                end
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            state_q     <= STOP;
            cur_half_q  <= HALF_W'(DEF_HALF);
            pend_half_q <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_half_q  <= cur_half_d;
            pend_half_q <= pend_half_d;
            pend_vld_q  <= pend_vld_d;
        end
    end

endmodule
